// File: rtl/irq_latch4b_pkg.sv
// irq_latch4b_pkg: shared state encoding, sizes and priority helper for the interrupt latch
package irq_latch4b_pkg;
  localparam int NUM_SRC = 4;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, HOLD = 2'd2} state_t;
  function automatic logic [1:0] lowest_set(input logic [NUM_SRC-1:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/irq_latch4b_sync_edge.sv
// irq_sync_edge: synchronises one active-low request and flags a falling edge or low level
module irq_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic EDGE_SEL    = 1'b1
) (
  input  logic C,
  input  logic CLR,
  input  logic IRQ_B,
  output logic set_req
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic hist_q, hist_d, s;
  always_comb begin
    s = sync_q[SYNC_STAGES-1];
    sync_d = {sync_q[SYNC_STAGES-2:0], IRQ_B};
    hist_d = s;
    set_req = EDGE_SEL ? (hist_q & ~s) : ~s;
  end
  always_ff @(posedge C or posedge CLR)
    if (CLR) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
endmodule

// File: rtl/irq_latch4b.sv
// irq_latch4b: four-source masked interrupt latch driving the KCPSM3 INTERRUPT/ACK handshake
module irq_latch4b
  import irq_latch4b_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] EDGE_SEL    = 4'b1111,
  parameter logic [3:0] MASK_INIT   = 4'b0000,
  parameter int         HOLDOFF_CYC = 2
) (
  input  logic       C,
  input  logic       CLR,
  input  logic [3:0] IRQ_B,
  input  logic       MASK_WE,
  input  logic [3:0] MASK_IN,
  input  logic       W1C_WE,
  input  logic [3:0] W1C_IN,
  input  logic       INTERRUPT_ACK,
  output logic       INTERRUPT,
  output logic [1:0] VECTOR,
  output logic [3:0] STATUS,
  output logic [3:0] PENDING
);
  logic [NUM_SRC-1:0] set_req, req, ack_clr;
  logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d, status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] vector_q, vector_d;
  logic int_q, int_d;
  state_t state_q, state_d;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_SEL(EDGE_SEL[i])) u_sync (
      .C(C), .CLR(CLR), .IRQ_B(IRQ_B[i]), .set_req(set_req[i])
    );
  end
  // Once asserted, INTERRUPT is only dropped by ACK: the CPU may already be committed.
  always_comb begin
    req = pending_q & mask_q;
    state_d = state_q;
    cnt_d = cnt_q;
    int_d = int_q;
    vector_d = vector_q;
    ack_clr = '0;
    case (state_q)
      IDLE:
        if (|req) begin
          state_d = ASSERT;
          int_d = 1'b1;
          vector_d = lowest_set(req);
        end
      ASSERT:
        if (INTERRUPT_ACK) begin
          int_d = 1'b0;
          ack_clr[vector_q] = 1'b1;
          cnt_d = CNT_W'(HOLDOFF_CYC);
          state_d = (HOLDOFF_CYC == 0) ? IDLE : HOLD;
        end
      HOLD: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_d <= 4'd1) ? IDLE : HOLD;
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q & ~(ack_clr | (W1C_WE ? W1C_IN : '0))) | set_req;
    mask_d = MASK_WE ? MASK_IN : mask_q;
    status_d = req;
  end
  always_ff @(posedge C or posedge CLR)
    if (CLR) begin
      state_q <= IDLE;
      cnt_q <= '0;
      int_q <= 1'b0;
      vector_q <= '0;
      pending_q <= '0;
      mask_q <= MASK_INIT;
      status_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      int_q <= int_d;
      vector_q <= vector_d;
      pending_q <= pending_d;
      mask_q <= mask_d;
      status_q <= status_d;
    end
  assign INTERRUPT = int_q;
  assign VECTOR = vector_q;
  assign STATUS = status_q;
  assign PENDING = pending_q;
endmodule

// File: tb/tb_irq_latch4b.sv
// tb_irq_latch4b: directed vectors with hand-computed expectations for irq_latch4b
module tb_irq_latch4b;
  logic c = 1'b0, clr;
  logic [3:0] irq_b, mask_in, w1c_in;
  logic mask_we, w1c_we, ack;
  logic interrupt;
  logic [1:0] vector;
  logic [3:0] status, pending;
  int errors = 0, checks = 0;

  irq_latch4b #(.EDGE_SEL(4'b1101)) dut (
    .C(c), .CLR(clr), .IRQ_B(irq_b), .MASK_WE(mask_we), .MASK_IN(mask_in),
    .W1C_WE(w1c_we), .W1C_IN(w1c_in), .INTERRUPT_ACK(ack),
    .INTERRUPT(interrupt), .VECTOR(vector), .STATUS(status), .PENDING(pending)
  );

  always #5 c = ~c;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    clr = 1'b1; irq_b = 4'hF; mask_in = '0; w1c_in = '0;
    mask_we = 1'b0; w1c_we = 1'b0; ack = 1'b0;
    tick(2);
    clr = 1'b0;
    chk("rst_int", interrupt, 0);
    chk("rst_vec", vector, 0);
    chk("rst_status", status, 0);
    chk("rst_pending", pending, 0);

    // masked pending, then enable mask
    irq_b[2] = 1'b0;
    tick(3);
    irq_b = 4'hF;
    chk("t1_pend_e2", pending, 4'b0100);
    tick();
    chk("t1_status_masked", status, 0);
    chk("t1_int_masked", interrupt, 0);
    mask_we = 1'b1; mask_in = 4'hF;
    tick();
    mask_we = 1'b0;
    tick();
    chk("t1_status", status, 4'b0100);
    chk("t1_int", interrupt, 1);
    chk("t1_vec", vector, 2);
    pulse_ack();
    chk("t1_pend_ack", pending, 0);
    chk("t1_int_ack", interrupt, 0);
    tick(4);
    chk("t1_idle", interrupt, 0);

    // simultaneous sources 3 and 1; source 1 is level mode so release it before ACK
    irq_b = 4'b0101;
    tick(2);
    chk("t2_pend_e1", pending, 0);
    tick();
    chk("t2_pend_e2", pending, 4'b1010);
    tick();
    chk("t2_int_e3", interrupt, 1);
    chk("t2_vec", vector, 1);
    irq_b = 4'b0111;
    tick(3);
    chk("t2_int_held", interrupt, 1);
    pulse_ack();
    chk("t2_pend_ack", pending, 4'b1000);
    chk("t2_int_h0", interrupt, 0);
    tick();
    chk("t2_int_h1", interrupt, 0);
    tick();
    chk("t2_int_re", interrupt, 1);
    chk("t2_vec_re", vector, 3);
    pulse_ack();
    chk("t2_pend_clr", pending, 0);
    irq_b = 4'hF;
    tick(4);

    // new edge on source 0 coinciding with ACK
    irq_b[0] = 1'b0;
    tick(4);
    chk("t3_int", interrupt, 1);
    chk("t3_vec", vector, 0);
    irq_b[0] = 1'b1;
    tick(3);
    irq_b[0] = 1'b0;
    tick(2);
    pulse_ack();
    chk("t3_pend_kept", pending, 4'b0001);
    chk("t3_int_drop", interrupt, 0);
    tick();
    chk("t3_int_hold", interrupt, 0);
    tick();
    chk("t3_int_re", interrupt, 1);
    chk("t3_vec_re", vector, 0);
    pulse_ack();
    chk("t3_pend_clr", pending, 0);
    irq_b = 4'hF;
    tick(4);

    // level source 1 held low overrides W1C and ACK
    irq_b[1] = 1'b0;
    tick(3);
    chk("t4_pend", pending, 4'b0010);
    tick();
    chk("t4_int", interrupt, 1);
    chk("t4_vec", vector, 1);
    w1c_we = 1'b1; w1c_in = 4'b0010;
    tick();
    w1c_we = 1'b0;
    chk("t4_w1c_over", pending, 4'b0010);
    chk("t4_int_kept", interrupt, 1);
    pulse_ack();
    chk("t4_pend_ack", pending, 4'b0010);
    chk("t4_int_ack", interrupt, 0);
    tick(2);
    chk("t4_int_re", interrupt, 1);
    chk("t4_vec_re", vector, 1);
    irq_b = 4'hF;
    tick(3);
    ack = 1'b1; w1c_we = 1'b1; w1c_in = 4'b0010;
    tick();
    ack = 1'b0; w1c_we = 1'b0;
    chk("t4_pend_rel", pending, 0);
    chk("t4_int_rel", interrupt, 0);
    tick(4);
    chk("t4_int_quiet", interrupt, 0);
    chk("t4_pend_quiet", pending, 0);

    // asynchronous clear mid-ASSERT
    irq_b[2] = 1'b0;
    tick(4);
    chk("t5_int", interrupt, 1);
    chk("t5_vec", vector, 2);
    chk("t5_status", status, 4'b0100);
    #2 clr = 1'b1;
    #1;
    chk("t5_clr_int", interrupt, 0);
    chk("t5_clr_vec", vector, 0);
    chk("t5_clr_status", status, 0);
    chk("t5_clr_pend", pending, 0);
    irq_b = 4'hF;
    tick();
    clr = 1'b0;
    mask_we = 1'b1; mask_in = 4'hF;
    tick();
    mask_we = 1'b0;
    pulse_ack();
    tick(2);
    chk("t5_stray_int", interrupt, 0);
    chk("t5_stray_vec", vector, 0);
    chk("t5_stray_pend", pending, 0);
    chk("t5_stray_status", status, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
